byte_to_word_pack_fifo: RTL and testbench
=========================================

Name: byte_to_word_pack_fifo

Overview:
Parametrised successor to the receive byte-to-word packer. It packs decoded payload bytes from dot11 into words of WORD_BYTES bytes and flushes any partial word at FCS time. It then appends one status word carrying FCS result, byte count and packet sequence number. All words are buffered in an output FIFO with valid/ready backpressure toward the DMA/AXIS side. The block sits between dot11 (byte_out/byte_out_strobe/fcs_out_strobe) and the host interface.

Parameters:
WORD_BYTES, 8, bytes per output word; 2..16; 8*WORD_BYTES >= 17+SN_WIDTH.
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries.
SN_WIDTH, 16, width of rx_pkt_sn.

Ports:
clock  in  1  the one clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
pkt_start  in  1  pulse at packet header valid; starts a new packet.
byte_in  in  8  payload byte.
byte_in_strobe  in  1  byte_in valid this cycle.
num_byte  in  16  expected packet length in bytes; sampled at pkt_start.
fcs_in_strobe  in  1  end of packet; FCS result valid.
fcs_ok  in  1  FCS check result; sampled with fcs_in_strobe.
rx_pkt_sn  in  SN_WIDTH  packet sequence number; sampled at pkt_start.
word_out  out  8*WORD_BYTES  FIFO head data.
word_out_last  out  1  head is the status word.
word_out_valid  out  1  FIFO non-empty.
word_out_ready  in  1  consumer accepts head when valid&ready.
fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy.
overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async): state S_IDLE; accumulator, byte counters, lane index = 0; FIFO empty. Outputs: word_out = 0, word_out_last = 0, word_out_valid = 0, fifo_level = 0, overflow = 0.
- States:
  - S_IDLE: waits for pkt_start.
  - S_PACK: accepts bytes.
  - S_FLUSH: pushes the partial word, one cycle.
  - S_STATUS: pushes the status word, one cycle, then returns to S_IDLE.
- pkt_start, from any state, including mid-packet or mid-flush:
  - clears accumulator, lane index and byte_cnt;
  - latches num_byte and rx_pkt_sn;
  - clears overflow;
  - enters S_PACK next cycle.
  - FIFO contents are kept.
  - pkt_start has priority over a simultaneous byte or FCS strobe, which are then ignored.
- Byte packing in S_PACK:
  - A byte_in_strobe writes byte_in into lane [8*lane+7:8*lane], little-endian, so the first byte lands in bits [7:0].
  - byte_cnt increments and lane increments.
  - Bytes beyond num_byte are ignored, with no count change.
  - When lane wraps from WORD_BYTES-1 to 0, the full word is pushed in the same cycle. It is visible at word_out one cycle later if the FIFO was empty.
- fcs_in_strobe in S_PACK:
  - A byte in the same cycle is packed first; if that byte completes a word, the word is pushed this cycle.
  - fcs_ok is latched.
  - Next state is S_FLUSH if the remaining lane count is > 0, else S_STATUS.
- S_FLUSH pushes the partial word, with unused upper lanes = 0.
- Status word: bits[15:0] = byte_cnt; bit16 = fcs_ok latched; bits[16+SN_WIDTH:17] = latched SN; upper bits 0; last = 1.
- Bytes and FCS strobes in S_IDLE, S_FLUSH and S_STATUS are ignored.
- FIFO:
  - Synchronous, show-ahead; entry width is 8*WORD_BYTES+1.
  - Pop when word_out_valid & word_out_ready.
  - Push when full with no simultaneous pop: the word is dropped and overflow is set to 1, held until pkt_start or reset.
  - Push when full with a simultaneous pop: accepted, level unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo depth.
  - fifo_level updates one cycle after push/pop.

Test Plan:
- WORD_BYTES=8, pkt_start with num_byte=16, SN=0x1234; bytes 0x00..0x0F; fcs_ok=1; ready=1 → three words: 0x0706050403020100, 0x0F0E0D0C0B0A0908 (last=0), then status 0x0000_0000_2469_0010 with bit16=1, SN<<17, last=1.
- num_byte=11, bytes 0xA0..0xAA, fcs_ok=0 → word 0xA7..A0, partial word 0x0000000000AAA9A8, status word with count 11 and bit16=0.
- Last byte and fcs_in_strobe in the same cycle, num_byte=8 → exactly two words (data, status); no zero-filled flush word.
- ready=0, FIFO_DEPTH_LOG2=2, 48 bytes → fifo_level reaches 4, overflow=1, first four words intact; then ready=1 → four words drain in order and valid drops.
- pkt_start after 5 bytes mid-packet, then 8 new bytes → stale bytes never appear; one word of the new bytes is output; overflow is cleared.
- Assert reset with the FIFO holding 3 words → word_out_valid=0, fifo_level=0 immediately (asynchronous), state S_IDLE.

Source files
------------

// File: rtl/byte_to_word_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_to_word_pack_fifo
// Brief    : Packs rx payload bytes into words, appends a status word per
//            packet and buffers everything in a show-ahead output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module byte_to_word_pack_fifo #(
  parameter int WORD_BYTES      = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int SN_WIDTH        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pkt_start,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_in_strobe,
  input  logic [15:0]                num_byte,
  input  logic                       fcs_in_strobe,
  input  logic                       fcs_ok,
  input  logic [SN_WIDTH-1:0]        rx_pkt_sn,
  output logic [8*WORD_BYTES-1:0]    word_out,
  output logic                       word_out_last,
  output logic                       word_out_valid,
  input  logic                       word_out_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       overflow
);

  localparam int c_WORD_W  = 8 * WORD_BYTES;
  localparam int c_ENTRY_W = c_WORD_W + 1;
  localparam int c_LANE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int c_LVL_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int c_DEPTH_N = 1 << FIFO_DEPTH_LOG2;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(WORD_BYTES - 1);
  localparam logic [c_LVL_W-1:0]  c_DEPTH     = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PACK   = 2'd1,
    S_FLUSH  = 2'd2,
    S_STATUS = 2'd3
  } state_t;

  state_t                      r_state, w_state_next;
  logic [c_WORD_W-1:0]         r_acc, w_acc_next, w_packed;
  logic [c_LANE_W-1:0]         r_lane, w_lane_next;
  logic [15:0]                 r_byte_cnt, w_cnt_next;
  logic [15:0]                 r_num_byte;
  logic [SN_WIDTH-1:0]         r_sn;
  logic                        r_fcs_ok, w_fcs_next;
  logic [c_WORD_W-1:0]         w_status;

  logic                        w_push, w_push_last;
  logic [c_WORD_W-1:0]         w_push_word;

  logic [c_ENTRY_W-1:0]        r_mem [0:c_DEPTH_N-1];
  logic [FIFO_DEPTH_LOG2-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_LVL_W-1:0]          r_level;
  logic                        r_overflow;
  logic                        w_full, w_valid, w_pop, w_wr_en;
  logic [c_ENTRY_W-1:0]        w_head;

  always_comb begin
    w_status                    = '0;
    w_status[15:0]              = r_byte_cnt;
    w_status[16]                = r_fcs_ok;
    w_status[16+SN_WIDTH:17]    = r_sn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_lane     <= '0;
      r_byte_cnt <= '0;
      r_num_byte <= '0;
      r_sn       <= '0;
      r_fcs_ok   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_lane     <= w_lane_next;
      r_byte_cnt <= w_cnt_next;
      r_fcs_ok   <= w_fcs_next;
      if (pkt_start) begin
        r_num_byte <= num_byte;
        r_sn       <= rx_pkt_sn;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_lane_next  = r_lane;
    w_cnt_next   = r_byte_cnt;
    w_fcs_next   = r_fcs_ok;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_push_word  = '0;
    w_packed     = r_acc;
    w_packed[8*r_lane +: 8] = byte_in;

    // pkt_start wins over any strobe or pending flush/status push
    if (pkt_start) begin
      w_state_next = S_PACK;
      w_acc_next   = '0;
      w_lane_next  = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_PACK: begin
          if (byte_in_strobe && (r_byte_cnt < r_num_byte)) begin
            w_cnt_next = r_byte_cnt + 16'd1;
            if (r_lane == c_LAST_LANE) begin
              w_push      = 1'b1;
              w_push_word = w_packed;
              w_acc_next  = '0;
              w_lane_next = '0;
            end else begin
              w_acc_next  = w_packed;
              w_lane_next = r_lane + c_LANE_W'(1);
            end
          end
          if (fcs_in_strobe) begin
            w_fcs_next   = fcs_ok;
            w_state_next = (w_lane_next != '0) ? S_FLUSH : S_STATUS;
          end
        end
        S_FLUSH: begin
          w_push       = 1'b1;
          w_push_word  = r_acc;
          w_acc_next   = '0;
          w_lane_next  = '0;
          w_state_next = S_STATUS;
        end
        S_STATUS: begin
          w_push       = 1'b1;
          w_push_last  = 1'b1;
          w_push_word  = w_status;
          w_state_next = S_IDLE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  assign w_full  = (r_level == c_DEPTH);
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid & word_out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_push_last, w_push_word};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (pkt_start)
        r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign word_out       = w_valid ? w_head[c_WORD_W-1:0] : '0;
  assign word_out_last  = w_valid & w_head[c_WORD_W];
  assign word_out_valid = w_valid;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_byte_to_word_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_to_word_pack_fifo
// Brief    : Randomised and directed bench for byte_to_word_pack_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_to_word_pack_fifo;

  localparam int WB    = 8;
  localparam int FDL   = 2;
  localparam int SNW   = 16;
  localparam int W     = 8 * WB;
  localparam int DEPTH = 1 << FDL;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            pkt_start = 1'b0;
  logic [7:0]      byte_in = 8'h00;
  logic            byte_in_strobe = 1'b0;
  logic [15:0]     num_byte = 16'd0;
  logic            fcs_in_strobe = 1'b0;
  logic            fcs_ok = 1'b0;
  logic [SNW-1:0]  rx_pkt_sn = '0;
  logic [W-1:0]    word_out;
  logic            word_out_last;
  logic            word_out_valid;
  logic            word_out_ready = 1'b0;
  logic [FDL:0]    fifo_level;
  logic            overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0]  exp_q[$];
  logic [7:0]  pkt_bytes[$];
  bit          rand_ready = 1'b0;
  logic        ready_force = 1'b1;

  always #5 clock = ~clock;

  byte_to_word_pack_fifo #(
    .WORD_BYTES(WB), .FIFO_DEPTH_LOG2(FDL), .SN_WIDTH(SNW)
  ) u_dut (
    .clock(clock), .reset(reset), .pkt_start(pkt_start),
    .byte_in(byte_in), .byte_in_strobe(byte_in_strobe), .num_byte(num_byte),
    .fcs_in_strobe(fcs_in_strobe), .fcs_ok(fcs_ok), .rx_pkt_sn(rx_pkt_sn),
    .word_out(word_out), .word_out_last(word_out_last),
    .word_out_valid(word_out_valid), .word_out_ready(word_out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    word_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // consumer side: a word handed over this cycle must match the model's next word
  always @(negedge clock) begin
    if (!reset && word_out_valid && word_out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", word_out_valid, 1'b0);
      else chk("word", {word_out_last, word_out}, exp_q.pop_front());
    end
  end

  // expected words of one packet: accepted bytes in groups of WB, then status
  task automatic model_pkt(input int nb, input logic [SNW-1:0] sn, input bit ok, input int keep);
    int          acc_n;
    int          nw;
    logic [W-1:0] d;
    nw    = 0;
    acc_n = (pkt_bytes.size() < nb) ? pkt_bytes.size() : nb;
    for (int b = 0; b < acc_n; b += WB) begin
      d = '0;
      for (int k = 0; k < WB && b + k < acc_n; k++) d[8*k +: 8] = pkt_bytes[b+k];
      if (nw < keep) exp_q.push_back({1'b0, d});
      nw++;
    end
    d = '0;
    d[15:0] = 16'(acc_n);
    d[16] = ok;
    d[16+SNW:17] = sn;
    if (nw < keep) exp_q.push_back({1'b1, d});
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_pkt(input int nb, input logic [SNW-1:0] sn, input bit ok,
                          input bit fcs_with_last, input bit gaps);
    pkt_start = 1'b1; num_byte = 16'(nb); rx_pkt_sn = sn;
    tick();
    pkt_start = 1'b0;
    for (int i = 0; i < pkt_bytes.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      byte_in = pkt_bytes[i];
      byte_in_strobe = 1'b1;
      if (fcs_with_last && i == pkt_bytes.size() - 1) begin
        fcs_in_strobe = 1'b1; fcs_ok = ok;
      end
      tick();
      byte_in_strobe = 1'b0; fcs_in_strobe = 1'b0; byte_in = 8'($urandom);
    end
    if (!fcs_with_last) begin
      fcs_in_strobe = 1'b1; fcs_ok = ok;
      tick();
      fcs_in_strobe = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    rand_ready = 1'b0; ready_force = 1'b1;
    while ((exp_q.size() != 0 || word_out_valid) && t < 300) begin
      tick(); t++;
    end
    chk({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_valid_low"}, word_out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, extra;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", word_out_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_word", {word_out_last, word_out}, 0);
    reset = 1'b0;
    tick();

    pkt_bytes.delete();
    for (int i = 0; i < 16; i++) pkt_bytes.push_back(8'(i));
    model_pkt(16, 16'h1234, 1'b1, 99);
    send_pkt(16, 16'h1234, 1'b1, 1'b0, 1'b0);
    wait_drain("seq16");

    pkt_bytes.delete();
    for (int i = 0; i < 11; i++) pkt_bytes.push_back(8'hA0 + 8'(i));
    model_pkt(11, 16'h0042, 1'b0, 99);
    send_pkt(11, 16'h0042, 1'b0, 1'b0, 1'b0);
    wait_drain("partial11");

    pkt_bytes.delete();
    for (int i = 0; i < 8; i++) pkt_bytes.push_back(8'($urandom));
    model_pkt(8, 16'h0007, 1'b1, 99);
    send_pkt(8, 16'h0007, 1'b1, 1'b1, 1'b0);
    wait_drain("fcs_with_last");

    ready_force = 1'b0;
    tick(); tick();
    pkt_bytes.delete();
    for (int i = 0; i < 48; i++) pkt_bytes.push_back(8'($urandom));
    model_pkt(48, 16'hBEEF, 1'b1, DEPTH);
    send_pkt(48, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_valid", word_out_valid, 1'b1);
    wait_drain("ovf");
    chk("ovf_sticky", overflow, 1'b1);

    pkt_start = 1'b1; num_byte = 16'd16; rx_pkt_sn = 16'h0AAA;
    tick();
    pkt_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'hE0 + 8'(i); byte_in_strobe = 1'b1;
      tick();
    end
    byte_in_strobe = 1'b0;
    pkt_bytes.delete();
    for (int i = 0; i < 8; i++) pkt_bytes.push_back(8'h50 + 8'(i));
    model_pkt(8, 16'h0BBB, 1'b1, 99);
    send_pkt(8, 16'h0BBB, 1'b1, 1'b0, 1'b0);
    chk("restart_ovf_clr", overflow, 1'b0);
    wait_drain("restart");

    for (int p = 0; p < 20; p++) begin
      repeat ($urandom_range(0, 2)) begin
        byte_in = 8'($urandom); byte_in_strobe = 1'b1;
        fcs_in_strobe = 1'($urandom_range(0, 1));
        tick();
      end
      byte_in_strobe = 1'b0; fcs_in_strobe = 1'b0;
      nb    = $urandom_range(1, 3 * WB);
      extra = $urandom_range(0, 2);
      pkt_bytes.delete();
      for (int i = 0; i < nb + extra; i++) pkt_bytes.push_back(8'($urandom));
      rx_pkt_sn = 16'($urandom);
      model_pkt(nb, rx_pkt_sn, 1'($urandom_range(0, 1)) == 1'b1 ? 1'b1 : 1'b0, 99);
      // status bit 16 of the just-modelled word carries the fcs result to drive
      send_pkt(nb, rx_pkt_sn, exp_q[exp_q.size()-1][16], 1'($urandom_range(0, 1)), 1'b1);
      rand_ready = 1'b1;
      repeat (4) tick();
      wait_drain("rand");
      chk("rand_no_ovf", overflow, 1'b0);
    end

    ready_force = 1'b0;
    tick(); tick();
    pkt_bytes.delete();
    for (int i = 0; i < 16; i++) pkt_bytes.push_back(8'($urandom));
    send_pkt(16, 16'h0101, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("pre_rst_level", fifo_level, 3);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", word_out_valid, 1'b0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_word", {word_out_last, word_out}, 0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    ready_force = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", word_out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
